dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 256 x 32 data memory.
- Port A is the CPU MEM stage; port B is the loader/debug port.
- Serialises requests into single-access transactions, drives the memory's write/read strobes, address and write data, and returns read data with a one-cycle ack pulse.
- Keeps all memory-side signals stable for the whole access cycle.

Parameters:
- ADDR_W, 8, memory address width (256 words).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  port A one-cycle completion pulse.
- a_rdata  out  DATA_W  port A read data; valid while a_ack = 1, held until the next A read completes.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as the A ports, for port B.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- Reset (asynchronous, any cycle including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0: mem_we, mem_re, mem_addr, mem_wdata, a_ack, b_ack, a_rdata, b_rdata.
  - Internal last_grant = B, so A wins the first contest.
  - Any in-flight transaction is aborted with no ack.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate (see below) and latch the winner id, we, addr and wdata into internal registers. Next state ACCESS.
- ACCESS, exactly one cycle:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched we; mem_re = not latched we.
  - If a read, capture mem_rdata into the winner's rdata register at the end of the cycle.
  - Next state RESP.
- RESP, exactly one cycle:
  - mem_we = mem_re = 0; mem_addr and mem_wdata hold their values.
  - Winner's ack = 1; the other port's ack stays 0.
  - The winner's req is ignored this cycle, because the requester may not yet have dropped it.
  - If the other port's req = 1: latch it and go directly to ACCESS (back-to-back).
  - Otherwise go to IDLE.
- Latency and throughput:
  - A request first seen in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2.
  - Sustained throughput is one access per 2 cycles when both ports alternate.
- Arbitration:
  - Default: fixed priority, A over B.
  - Both requesting in IDLE: A wins; B is granted from A's RESP cycle.
  - Round-robin variant: see Optional Feature.
- Request rules:
  - A requester holds req, we, addr and wdata stable until ack.
  - The arbiter latches the fields at grant, so later changes do not affect the access.
  - req dropped before ack: the transaction still completes and ack still pulses.
  - A write returns ack with rdata unchanged.
- mem_we and mem_re are never both 1, and are 1 only in ACCESS.
- No more than one transaction is outstanding.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On contention in IDLE, grant the port opposite last_grant.
  - last_grant updates at every grant.
  - RESP-to-ACCESS hand-off is unchanged, since it is already alternating.
- Not defined: fixed priority A over B.
  - last_grant is not implemented.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, release, no requests -> all outputs 0, state IDLE for 10 cycles.
- A write then read:
  - a_req = 1, a_we = 1, a_addr = 8'h10, a_wdata = 32'hDEADBEEF -> mem_we = 1 for exactly one cycle with mem_addr = 8'h10, a_ack pulses 2 cycles after the request.
  - Then read 8'h10 -> mem_re = 1 for one cycle, a_ack with a_rdata = 32'hDEADBEEF.
- Contention:
  - Setup: A reads 8'h01 while B writes 8'h02 = 32'h12345678, both requests raised in the same cycle.
  - Without DMEM_ARB_RR_EN -> A acked at N+2; B ACCESS at N+3; b_ack at N+4.
  - With DMEM_ARB_RR_EN, after a prior B grant -> same ordering; after a prior A grant -> B is served first.
- Back-to-back: both ports request continuously for 8 transactions -> acks alternate A,B,A,B; one access every 2 cycles; mem_we and mem_re never both high.
- Early drop: a_req dropped in the ACCESS cycle -> a_ack still pulses in RESP; state returns to IDLE.
- Reset mid-operation: assert rst_n = 0 during the ACCESS of a write -> mem_we drops to 0 immediately with no ack; after release, a fresh request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and sequencer in front of the 256 x 32 data memory.
// Port A is the CPU MEM stage and port B is the loader/debug port. Each grant
// becomes a single memory access. The memory-side signals stay stable for the
// whole access cycle. Each completed transaction returns a one-cycle ack pulse
// to the port that won.
//
// Transaction timeline: IDLE -> ACCESS (1 cycle) -> RESP (1 cycle).
// If the other port is waiting during RESP, the arbiter goes straight back to
// ACCESS for that port. Alternating ports can therefore sustain one access
// every two cycles.
//
// Configuration macro:
//   DMEM_ARB_RR_EN  when defined, contention in IDLE is resolved round-robin
//                   (the grant goes to the port opposite the last grant).
//                   When undefined, A has fixed priority over B.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   a_req/a_we         port A request (held until a_ack), 1 = write
//   a_addr/a_wdata     port A word address and write data
//   a_ack/a_rdata      port A completion pulse and read data (held)
//   b_*                same set of signals for port B
//   mem_we/mem_re      memory write/read strobes (only in ACCESS, never both)
//   mem_addr/mem_wdata memory address and write data (from latched request)
//   mem_rdata          memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Port id encoding: 0 = A, 1 = B.
  logic              grant_load;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

`ifdef DMEM_ARB_RR_EN
  logic              last_grant;
`endif

  // Next-state and grant decision. The current winner's req is not looked at
  // in RESP, because that requester may still be holding req while it
  // observes its ack.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant_load = 1'b1;
          state_nxt  = ACCESS;
`ifdef DMEM_ARB_RR_EN
          if (a_req && b_req) grant_id = !last_grant;
          else                grant_id = !a_req;
`else
          grant_id = !a_req;
`endif
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (lat_id ? a_req : b_req) begin
          grant_load = 1'b1;
          grant_id   = !lat_id;
          state_nxt  = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sel_we    = grant_id ? b_we    : a_we;
  assign sel_addr  = grant_id ? b_addr  : a_addr;
  assign sel_wdata = grant_id ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request fields are captured at grant. After that, the requester may
  // change its inputs without affecting the access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_load) begin
      lat_id    <= grant_id;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // Read data is captured at the end of ACCESS, so it is already valid when
  // the ack rises in RESP. It is then held until the next read for the same
  // port completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS && !lat_we) begin
      if (lat_id) b_rdata <= mem_rdata;
      else        a_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Reset value B means A wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_grant <= 1'b1;
    else if (grant_load) last_grant <= grant_id;
  end
`endif

  // Strobes and acks decode directly from the state register. A reset in the
  // middle of a transaction therefore drops them immediately.
  assign mem_we    = (state == ACCESS) &&  lat_we;
  assign mem_re    = (state == ACCESS) && !lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign a_ack     = (state == RESP) && !lat_id;
  assign b_ack     = (state == RESP) &&  lat_id;

endmodule
